// File: rtl/ddr_cmd_bundle_decoder.sv
// Buffers scheduler command bundles in a FIFO and decodes one bundle per cycle into per-slot
// DDR4 PHY strobes and fields. Optional per-type command counters: `define DDR_DECODER_STATS_EN.
module ddr_cmd_bundle_decoder #(
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_WIDTH  = 32,
  parameter int BG_WIDTH    = 2,
  parameter int BANK_WIDTH  = 2,
  parameter int ROW_WIDTH   = 17,
  parameter int COL_WIDTH   = 10,
  parameter int WDATA_WIDTH = 512,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_SLOTS*SLOT_WIDTH+WDATA_WIDTH-1:0] in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic                                        phy_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]             fifo_level,
  output logic                                        out_valid,
  output logic [NUM_SLOTS-1:0]                        ddr_write,
  output logic [NUM_SLOTS-1:0]                        ddr_read,
  output logic [NUM_SLOTS-1:0]                        ddr_pre,
  output logic [NUM_SLOTS-1:0]                        ddr_act,
  output logic [NUM_SLOTS-1:0]                        ddr_ref,
  output logic [NUM_SLOTS-1:0]                        ddr_zq,
  output logic [NUM_SLOTS-1:0]                        ddr_nop,
  output logic [NUM_SLOTS-1:0]                        ddr_ap,
  output logic [NUM_SLOTS-1:0]                        ddr_half_bl,
  output logic [NUM_SLOTS-1:0]                        ddr_pall,
  output logic [NUM_SLOTS*BG_WIDTH-1:0]               ddr_bg,
  output logic [NUM_SLOTS*BANK_WIDTH-1:0]             ddr_bank,
  output logic [NUM_SLOTS*ROW_WIDTH-1:0]              ddr_row,
  output logic [NUM_SLOTS*COL_WIDTH-1:0]              ddr_col,
  output logic [WDATA_WIDTH-1:0]                      ddr_wdata,
  output logic                                        ddr_wdata_valid,
  output logic                                        err_illegal,
  input  logic                                        err_clear
`ifdef DDR_DECODER_STATS_EN
  ,
  input  logic                                        stat_clr,
  output logic [5*32-1:0]                             stat_cnt
`endif
);

  localparam int SLOTS_W = NUM_SLOTS * SLOT_WIDTH;
  localparam int DATA_W  = SLOTS_W + WDATA_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int FLD_O   = 3 + BANK_WIDTH + BG_WIDTH;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_s, pop_s;

  logic [NUM_SLOTS-1:0]            dec_write, dec_read, dec_pre, dec_act, dec_refresh;
  logic [NUM_SLOTS-1:0]            dec_zq, dec_nop, dec_ap, dec_half_bl, dec_pall;
  logic [NUM_SLOTS*BG_WIDTH-1:0]   dec_bg;
  logic [NUM_SLOTS*BANK_WIDTH-1:0] dec_bank;
  logic [NUM_SLOTS*ROW_WIDTH-1:0]  dec_row;
  logic [NUM_SLOTS*COL_WIDTH-1:0]  dec_col;
  logic [WDATA_WIDTH-1:0]          dec_wdata;
  logic                            dec_illegal;

  logic                            out_valid_q, out_valid_d, wdata_valid_q, wdata_valid_d;
  logic                            err_q, err_d;
  logic [NUM_SLOTS-1:0]            write_q, write_d, read_q, read_d, pre_q, pre_d;
  logic [NUM_SLOTS-1:0]            act_q, act_d, refresh_q, refresh_d, zq_q, zq_d;
  logic [NUM_SLOTS-1:0]            nop_q, nop_d, ap_q, ap_d, half_bl_q, half_bl_d;
  logic [NUM_SLOTS-1:0]            pall_q, pall_d;
  logic [NUM_SLOTS*BG_WIDTH-1:0]   bg_q, bg_d;
  logic [NUM_SLOTS*BANK_WIDTH-1:0] bank_q, bank_d;
  logic [NUM_SLOTS*ROW_WIDTH-1:0]  row_q, row_d;
  logic [NUM_SLOTS*COL_WIDTH-1:0]  col_q, col_d;
  logic [WDATA_WIDTH-1:0]          wdata_q, wdata_d;

  assign in_ready   = (level_q != FULL_LVL);
  assign push_s     = in_valid & in_ready;
  assign pop_s      = phy_ready & (level_q != {LVL_W{1'b0}});
  assign fifo_level = level_q;

  // FIFO pointer, level and storage next-state; a full FIFO never passes a bundle straight through
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = in_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Decode the head bundle; fields are copied for every slot whatever its type
  always_comb begin
    dec_write   = '0;
    dec_read    = '0;
    dec_pre     = '0;
    dec_act     = '0;
    dec_refresh = '0;
    dec_zq      = '0;
    dec_nop     = '0;
    dec_ap      = '0;
    dec_half_bl = '0;
    dec_pall    = '0;
    dec_bg      = '0;
    dec_bank    = '0;
    dec_row     = '0;
    dec_col     = '0;
    dec_illegal = 1'b0;
    dec_wdata   = fifo_mem_q[rd_ptr_q][DATA_W-1:SLOTS_W];
    for (int i = 0; i < NUM_SLOTS; i++) begin
      case (fifo_mem_q[rd_ptr_q][i*SLOT_WIDTH +: 3])
        3'd0:    dec_nop[i]     = 1'b1;
        3'd1:    dec_pre[i]     = 1'b1;
        3'd2:    dec_act[i]     = 1'b1;
        3'd3:    dec_read[i]    = 1'b1;
        3'd4:    dec_write[i]   = 1'b1;
        3'd5:    dec_refresh[i] = 1'b1;
        3'd6:    dec_zq[i]      = 1'b1;
        default: begin
          dec_nop[i]  = 1'b1;
          dec_illegal = 1'b1;
        end
      endcase
      dec_bank[i*BANK_WIDTH +: BANK_WIDTH] = fifo_mem_q[rd_ptr_q][i*SLOT_WIDTH + 3 +: BANK_WIDTH];
      dec_bg[i*BG_WIDTH +: BG_WIDTH]       = fifo_mem_q[rd_ptr_q][i*SLOT_WIDTH + 3 + BANK_WIDTH +: BG_WIDTH];
      dec_row[i*ROW_WIDTH +: ROW_WIDTH]    = fifo_mem_q[rd_ptr_q][i*SLOT_WIDTH + FLD_O +: ROW_WIDTH];
      dec_col[i*COL_WIDTH +: COL_WIDTH]    = fifo_mem_q[rd_ptr_q][i*SLOT_WIDTH + FLD_O +: COL_WIDTH];
      dec_pall[i]    = fifo_mem_q[rd_ptr_q][i*SLOT_WIDTH + FLD_O];
      dec_ap[i]      = fifo_mem_q[rd_ptr_q][i*SLOT_WIDTH + FLD_O + ROW_WIDTH];
      dec_half_bl[i] = fifo_mem_q[rd_ptr_q][i*SLOT_WIDTH + FLD_O + ROW_WIDTH + 1];
    end
  end

  // Output register next-state: hold under backpressure, load on pop, idle bundle otherwise
  always_comb begin
    if (!phy_ready) begin
      out_valid_d   = out_valid_q;
      write_d       = write_q;
      read_d        = read_q;
      pre_d         = pre_q;
      act_d         = act_q;
      refresh_d     = refresh_q;
      zq_d          = zq_q;
      nop_d         = nop_q;
      ap_d          = ap_q;
      half_bl_d     = half_bl_q;
      pall_d        = pall_q;
      bg_d          = bg_q;
      bank_d        = bank_q;
      row_d         = row_q;
      col_d         = col_q;
      wdata_d       = wdata_q;
      wdata_valid_d = wdata_valid_q;
    end else if (pop_s) begin
      out_valid_d   = 1'b1;
      write_d       = dec_write;
      read_d        = dec_read;
      pre_d         = dec_pre;
      act_d         = dec_act;
      refresh_d     = dec_refresh;
      zq_d          = dec_zq;
      nop_d         = dec_nop;
      ap_d          = dec_ap;
      half_bl_d     = dec_half_bl;
      pall_d        = dec_pall;
      bg_d          = dec_bg;
      bank_d        = dec_bank;
      row_d         = dec_row;
      col_d         = dec_col;
      wdata_d       = dec_wdata;
      wdata_valid_d = |dec_write;
    end else begin
      out_valid_d   = 1'b0;
      write_d       = '0;
      read_d        = '0;
      pre_d         = '0;
      act_d         = '0;
      refresh_d     = '0;
      zq_d          = '0;
      nop_d         = '0;
      ap_d          = '0;
      half_bl_d     = '0;
      pall_d        = '0;
      bg_d          = '0;
      bank_d        = '0;
      row_d         = '0;
      col_d         = '0;
      wdata_d       = '0;
      wdata_valid_d = 1'b0;
    end
    if (err_clear) begin
      err_d = 1'b0;
    end else if (pop_s && dec_illegal) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Bundle storage; contents are don't-care while the level says empty
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      write_q       <= '0;
      read_q        <= '0;
      pre_q         <= '0;
      act_q         <= '0;
      refresh_q     <= '0;
      zq_q          <= '0;
      nop_q         <= '0;
      ap_q          <= '0;
      half_bl_q     <= '0;
      pall_q        <= '0;
      bg_q          <= '0;
      bank_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      wdata_q       <= '0;
      wdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      write_q       <= write_d;
      read_q        <= read_d;
      pre_q         <= pre_d;
      act_q         <= act_d;
      refresh_q     <= refresh_d;
      zq_q          <= zq_d;
      nop_q         <= nop_d;
      ap_q          <= ap_d;
      half_bl_q     <= half_bl_d;
      pall_q        <= pall_d;
      bg_q          <= bg_d;
      bank_q        <= bank_d;
      row_q         <= row_d;
      col_q         <= col_d;
      wdata_q       <= wdata_d;
      wdata_valid_q <= wdata_valid_d;
      err_q         <= err_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign ddr_write       = write_q;
  assign ddr_read        = read_q;
  assign ddr_pre         = pre_q;
  assign ddr_act         = act_q;
  assign ddr_ref         = refresh_q;
  assign ddr_zq          = zq_q;
  assign ddr_nop         = nop_q;
  assign ddr_ap          = ap_q;
  assign ddr_half_bl     = half_bl_q;
  assign ddr_pall        = pall_q;
  assign ddr_bg          = bg_q;
  assign ddr_bank        = bank_q;
  assign ddr_row         = row_q;
  assign ddr_col         = col_q;
  assign ddr_wdata       = wdata_q;
  assign ddr_wdata_valid = wdata_valid_q;
  assign err_illegal     = err_q;

`ifdef DDR_DECODER_STATS_EN
  function automatic logic [31:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [31:0] c;
    c = 32'd0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      c = c + {31'd0, v[k]};
    end
    return c;
  endfunction

  // Counter order low to high: rd, wr, act, pre, ref
  logic [31:0]          stat_q   [5];
  logic [31:0]          stat_d   [5];
  logic [NUM_SLOTS-1:0] stat_src [5];

  // Counter next-state; clear wins over a same-cycle increment
  always_comb begin
    stat_src[0] = dec_read;
    stat_src[1] = dec_write;
    stat_src[2] = dec_act;
    stat_src[3] = dec_pre;
    stat_src[4] = dec_refresh;
    for (int k = 0; k < 5; k++) begin
      if (stat_clr) begin
        stat_d[k] = 32'd0;
      end else if (pop_s) begin
        stat_d[k] = stat_q[k] + popcount(stat_src[k]);
      end else begin
        stat_d[k] = stat_q[k];
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 5; k++) begin
        stat_q[k] <= 32'd0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = {stat_q[4], stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif

endmodule

// File: tb/tb_ddr_cmd_bundle_decoder.sv
// Directed self-checking bench for ddr_cmd_bundle_decoder (default parameters).
module tb_ddr_cmd_bundle_decoder;
  localparam int NS = 4;
  localparam int SW = 32;
  localparam int WD = 512;
  localparam int DW = NS * SW + WD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          phy_ready = 1'b0;
  logic          err_clear = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, ddr_wdata_valid, err_illegal;
  logic [2:0]    fifo_level;
  logic [NS-1:0] ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_nop;
  logic [NS-1:0] ddr_ap, ddr_half_bl, ddr_pall;
  logic [7:0]    ddr_bg, ddr_bank;
  logic [67:0]   ddr_row;
  logic [39:0]   ddr_col;
  logic [WD-1:0] ddr_wdata;
`ifdef DDR_DECODER_STATS_EN
  logic          stat_clr = 1'b0;
  logic [159:0]  stat_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  ddr_cmd_bundle_decoder dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .phy_ready(phy_ready), .fifo_level(fifo_level), .out_valid(out_valid),
    .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_pre(ddr_pre), .ddr_act(ddr_act),
    .ddr_ref(ddr_ref), .ddr_zq(ddr_zq), .ddr_nop(ddr_nop), .ddr_ap(ddr_ap),
    .ddr_half_bl(ddr_half_bl), .ddr_pall(ddr_pall), .ddr_bg(ddr_bg), .ddr_bank(ddr_bank),
    .ddr_row(ddr_row), .ddr_col(ddr_col), .ddr_wdata(ddr_wdata),
    .ddr_wdata_valid(ddr_wdata_valid), .err_illegal(err_illegal), .err_clear(err_clear)
`ifdef DDR_DECODER_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // slot: [2:0] type, [4:3] bank, [6:5] bg, [23:7] row (col = low 10, pall = bit 7), [24] ap, [25] half_bl
  function automatic logic [SW-1:0] mk_slot(input logic [2:0] t, input logic [1:0] bank,
                                            input logic [1:0] bg, input logic [16:0] addr,
                                            input logic ap, input logic hbl);
    logic [SW-1:0] s;
    s        = '0;
    s[2:0]   = t;
    s[4:3]   = bank;
    s[6:5]   = bg;
    s[23:7]  = addr;
    s[24]    = ap;
    s[25]    = hbl;
    return s;
  endfunction

  function automatic logic [DW-1:0] mk_bundle(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                                              input logic [SW-1:0] s2, input logic [SW-1:0] s3,
                                              input logic [WD-1:0] wd);
    return {wd, s3, s2, s1, s0};
  endfunction

  // Inputs change just after a falling edge; outputs are sampled at the next falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; phy_ready = 1'b1;
    in_data = mk_bundle(mk_slot(3'd4, 2'd1, 2'd1, 17'h1FFFF, 1'b1, 1'b1), '0, '0, '0, {WD{1'b1}});
    tick(); tick();
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if ({ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_nop, ddr_ap, ddr_half_bl, ddr_pall} !== 40'd0) begin
      fails++; $display("FAIL reset_strobes: got nonzero strobes want 0"); end
    checks++; if ({ddr_bg, ddr_bank, ddr_row, ddr_col} !== 124'd0) begin fails++; $display("FAIL reset_fields: got nonzero fields want 0"); end
    checks++; if (ddr_wdata !== '0 || ddr_wdata_valid !== 1'b0) begin fails++; $display("FAIL reset_wdata: got valid %b want 0", ddr_wdata_valid); end
    checks++; if (err_illegal !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_illegal); end
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
    checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_after_release: level %0d valid %b want 0 0", fifo_level, out_valid); end
  endtask

  task automatic test_single();
    phy_ready = 1'b1; in_valid = 1'b1;
    in_data = mk_bundle(mk_slot(3'd2, 2'd1, 2'd2, 17'h1ABCD, 1'b0, 1'b1),
                        mk_slot(3'd4, 2'd0, 2'd0, 17'h00155, 1'b1, 1'b0), '0, '0, {64{8'hA5}});
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_level !== 3'd1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL single_latency: level %0d valid %b want 1 0", fifo_level, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (ddr_act !== 4'b0001) begin fails++; $display("FAIL single_act: got %b want 0001", ddr_act); end
    checks++; if (ddr_write !== 4'b0010) begin fails++; $display("FAIL single_write: got %b want 0010", ddr_write); end
    checks++; if (ddr_nop !== 4'b1100) begin fails++; $display("FAIL single_nop: got %b want 1100", ddr_nop); end
    checks++; if ({ddr_read, ddr_pre, ddr_ref, ddr_zq} !== 16'd0) begin fails++; $display("FAIL single_other_strobes: got nonzero want 0"); end
    checks++; if (ddr_row[16:0] !== 17'h1ABCD) begin fails++; $display("FAIL single_row0: got %h want 1abcd", ddr_row[16:0]); end
    checks++; if (ddr_row[33:17] !== 17'h00155) begin fails++; $display("FAIL single_row1: got %h want 00155", ddr_row[33:17]); end
    checks++; if (ddr_col[19:10] !== 10'h155) begin fails++; $display("FAIL single_col1: got %h want 155", ddr_col[19:10]); end
    checks++; if (ddr_col[9:0] !== 10'h3CD) begin fails++; $display("FAIL single_col0: got %h want 3cd", ddr_col[9:0]); end
    checks++; if (ddr_bank[1:0] !== 2'd1 || ddr_bg[1:0] !== 2'd2) begin
      fails++; $display("FAIL single_bank_bg: bank %0d bg %0d want 1 2", ddr_bank[1:0], ddr_bg[1:0]); end
    checks++; if (ddr_pall !== 4'b0011 || ddr_ap !== 4'b0010 || ddr_half_bl !== 4'b0001) begin
      fails++; $display("FAIL single_flags: pall %b ap %b hbl %b want 0011 0010 0001", ddr_pall, ddr_ap, ddr_half_bl); end
    checks++; if (ddr_wdata !== {64{8'hA5}} || ddr_wdata_valid !== 1'b1) begin
      fails++; $display("FAIL single_wdata: got %h valid %b want a5.. 1", ddr_wdata[31:0], ddr_wdata_valid); end
    tick();
    checks++; if (out_valid !== 1'b0 || ddr_wdata_valid !== 1'b0 || ddr_wdata !== '0 || ddr_write !== 4'd0) begin
      fails++; $display("FAIL single_idle: valid %b wvalid %b want 0 0", out_valid, ddr_wdata_valid); end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_lvl [5];
    exp_lvl[0] = 3'd3; exp_lvl[1] = 3'd3; exp_lvl[2] = 3'd2; exp_lvl[3] = 3'd1; exp_lvl[4] = 3'd0;
    phy_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = mk_bundle(mk_slot(3'd3, 2'(k), 2'd0, 17'(k + 100), 1'b0, 1'b0), '0, '0, '0, WD'(k + 4096));
      tick();
    end
    in_data = mk_bundle(mk_slot(3'd3, 2'd0, 2'd0, 17'd104, 1'b0, 1'b0), '0, '0, '0, WD'(4100));
    checks++; if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_full: level %0d ready %b want 4 0", fifo_level, in_ready); end
    tick();
    checks++; if (fifo_level !== 3'd4 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_held: level %0d valid %b want 4 0", fifo_level, out_valid); end
    phy_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || ddr_wdata !== WD'(k + 4096) || ddr_read !== 4'b0001) begin
        fails++; $display("FAIL bp_order%0d: wdata %0d valid %b want %0d 1", k, ddr_wdata[15:0], out_valid, k + 4096); end
      checks++; if (fifo_level !== exp_lvl[k]) begin
        fails++; $display("FAIL bp_level%0d: got %0d want %0d", k, fifo_level, exp_lvl[k]); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: valid %b want 0", out_valid); end
  endtask

  task automatic test_toggle();
    phy_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = mk_bundle('0, mk_slot(3'd1, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0), '0, '0, WD'(k + 10));
      tick();
    end
    in_valid = 1'b0; phy_ready = 1'b1;
    tick();
    checks++; if (ddr_wdata !== WD'(10) || out_valid !== 1'b1 || fifo_level !== 3'd2) begin
      fails++; $display("FAIL tog_first: wdata %0d level %0d want 10 2", ddr_wdata[15:0], fifo_level); end
    phy_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ddr_wdata !== WD'(10) || out_valid !== 1'b1 || ddr_pre !== 4'b0010 || fifo_level !== 3'd2) begin
        fails++; $display("FAIL tog_hold%0d: wdata %0d valid %b level %0d want 10 1 2", k, ddr_wdata[15:0], out_valid, fifo_level); end
    end
    phy_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ddr_wdata !== WD'(k + 11) || out_valid !== 1'b1 || fifo_level !== 3'(1 - k)) begin
        fails++; $display("FAIL tog_resume%0d: wdata %0d level %0d want %0d %0d", k, ddr_wdata[15:0], fifo_level, k + 11, 1 - k); end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL tog_idle: valid %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    phy_ready = 1'b1; in_valid = 1'b1;
    in_data = mk_bundle(mk_slot(3'd3, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0), mk_slot(3'd1, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0),
                        mk_slot(3'd7, 2'd3, 2'd3, 17'h0ABCD, 1'b0, 1'b0), mk_slot(3'd5, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0), '0);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (ddr_nop !== 4'b0100 || ddr_read !== 4'b0001 || ddr_pre !== 4'b0010 || ddr_ref !== 4'b1000) begin
      fails++; $display("FAIL ill_strobes: nop %b rd %b pre %b ref %b want 0100 0001 0010 1000", ddr_nop, ddr_read, ddr_pre, ddr_ref); end
    checks++; if (ddr_row[50:34] !== 17'h0ABCD || ddr_bank[5:4] !== 2'd3) begin
      fails++; $display("FAIL ill_fields: row %h bank %0d want 0abcd 3", ddr_row[50:34], ddr_bank[5:4]); end
    checks++; if (err_illegal !== 1'b1 || ddr_wdata_valid !== 1'b0) begin
      fails++; $display("FAIL ill_err_set: err %b wvalid %b want 1 0", err_illegal, ddr_wdata_valid); end
    tick();
    checks++; if (err_illegal !== 1'b1) begin fails++; $display("FAIL ill_sticky: got %b want 1", err_illegal); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (err_illegal !== 1'b0) begin fails++; $display("FAIL ill_clear: got %b want 0", err_illegal); end
    in_valid = 1'b1;
    in_data  = mk_bundle(mk_slot(3'd6, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0), mk_slot(3'd7, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0), '0, '0, '0);
    tick();
    in_valid = 1'b0; err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++; if (ddr_zq !== 4'b0001 || ddr_nop !== 4'b1110) begin
      fails++; $display("FAIL ill_zq: zq %b nop %b want 0001 1110", ddr_zq, ddr_nop); end
    checks++; if (err_illegal !== 1'b0) begin fails++; $display("FAIL ill_clear_priority: got %b want 0", err_illegal); end
  endtask

  task automatic test_reset_mid();
    phy_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = mk_bundle(mk_slot(3'd4, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0), '0, '0, '0, WD'(k + 50));
      tick();
    end
    in_valid = 1'b0; phy_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || fifo_level !== 3'd2 || ddr_wdata !== WD'(50)) begin
      fails++; $display("FAIL rmid_pre: valid %b level %0d want 1 2", out_valid, fifo_level); end
    phy_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0 || ddr_wdata !== '0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL rmid_reset: level %0d valid %b ready %b want 0 0 1", fifo_level, out_valid, in_ready); end
    phy_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (out_valid !== 1'b0 || ddr_write !== 4'd0) begin
        fails++; $display("FAIL rmid_dropped%0d: valid %b write %b want 0 0000", k, out_valid, ddr_write); end
    end
  endtask

`ifdef DDR_DECODER_STATS_EN
  task automatic test_stats();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++; if (stat_cnt !== 160'd0) begin fails++; $display("FAIL stats_clear0: got %h want 0", stat_cnt); end
    phy_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = mk_bundle(mk_slot(3'd3, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0), mk_slot(3'd3, 2'd1, 2'd0, 17'd0, 1'b0, 1'b0),
                           mk_slot(3'd4, 2'd0, 2'd0, 17'd0, 1'b0, 1'b0), '0, WD'(k));
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (stat_cnt !== {32'd0, 32'd0, 32'd0, 32'd3, 32'd6}) begin
      fails++; $display("FAIL stats_count: got %h want ref0 pre0 act0 wr3 rd6", stat_cnt); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++; if (stat_cnt !== 160'd0) begin fails++; $display("FAIL stats_clear: got %h want 0", stat_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_toggle();
    test_illegal();
    test_reset_mid();
`ifdef DDR_DECODER_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
